// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the block-memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W  = 28;
  localparam int MEM_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between the I-cache and D-cache block requests.
// ARB_ROUND_ROBIN_EN: ties alternate using the last-grant owner.
// Without it, the D-cache wins every tie and no last-grant input exists.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   i_ic_req,
  input  logic   i_dc_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t i_last_grant,
`endif
  output logic   o_valid,
  output owner_t o_owner
);

  // Combinational winner: a lone requester wins, ties resolved by mode
  always_comb begin
    o_valid = i_ic_req | i_dc_req;
    o_owner = OWN_DC;
    if (i_ic_req && !i_dc_req) begin
      o_owner = OWN_IC;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (i_ic_req && i_dc_req && (i_last_grant == OWN_DC)) begin
      o_owner = OWN_IC;
    end
`endif
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// Shares one 128-bit block memory port between I-cache refills and
// D-cache refills/write-backs. One transaction at a time:
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// ARB_ROUND_ROBIN_EN selects alternating tie-break; default is D-cache priority.
//
// state | meaning
// IDLE  | arbitrate, latch owner/op/address/data on a winner
// ISSUE | memory strobe and latched address/data on the port
// WAIT  | hold the port until mem_busywait is sampled low
// RESP  | strobes low, one-cycle done pulse to the owner
module mem_block_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int BLOCK_W = MEM_BLOCK_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ic_read,
  input  logic [ADDR_W-1:0]  ic_address,
  output logic [BLOCK_W-1:0] ic_readdata,
  output logic               ic_busywait,
  input  logic               dc_read,
  input  logic               dc_write,
  input  logic [ADDR_W-1:0]  dc_address,
  input  logic [BLOCK_W-1:0] dc_writedata,
  output logic [BLOCK_W-1:0] dc_readdata,
  output logic               dc_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  state_t               r_state;
  owner_t               r_owner;
  op_t                  r_op;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [ADDR_W-1:0]    r_mem_address;
  logic [BLOCK_W-1:0]   r_mem_writedata;
  logic [BLOCK_W-1:0]   r_ic_readdata;
  logic [BLOCK_W-1:0]   r_dc_readdata;
  logic                 r_ic_done;
  logic                 r_dc_done;

  logic                 w_ic_req;
  logic                 w_dc_req;
  logic                 w_grant;
  owner_t               w_winner;
  logic                 w_owner_active;

  assign w_ic_req = ic_read;
  assign w_dc_req = dc_read | dc_write;

  // The owner may have dropped its request mid-transaction; if so its
  // result and release are suppressed.
  assign w_owner_active = (r_owner == OWN_IC) ? w_ic_req : w_dc_req;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t r_last_grant;

  // Last-grant tracks every grant so ties alternate
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_grant <= OWN_IC;
    end else if ((r_state == IDLE) && w_grant) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  mem_arb_select u_select (
    .i_ic_req     (w_ic_req),
    .i_dc_req     (w_dc_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_grant (r_last_grant),
`endif
    .o_valid      (w_grant),
    .o_owner      (w_winner)
  );

  // Transaction FSM with latched request, memory strobes and done pulses
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_owner         <= OWN_IC;
      r_op            <= OP_RD;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_ic_readdata   <= '0;
      r_dc_readdata   <= '0;
      r_ic_done       <= 1'b0;
      r_dc_done       <= 1'b0;
    end else begin
      r_ic_done <= 1'b0;
      r_dc_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_state <= ISSUE;
            if (w_winner == OWN_DC) begin
              // read+write together is a write-back
              r_op            <= dc_write ? OP_WR : OP_RD;
              r_mem_read      <= ~dc_write;
              r_mem_write     <= dc_write;
              r_mem_address   <= dc_address;
              r_mem_writedata <= dc_writedata;
            end else begin
              r_op          <= OP_RD;
              r_mem_read    <= 1'b1;
              r_mem_write   <= 1'b0;
              r_mem_address <= ic_address;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (!mem_busywait) begin
            r_state     <= RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_owner_active) begin
              if (r_owner == OWN_IC) begin
                r_ic_done <= 1'b1;
                if (r_op == OP_RD) r_ic_readdata <= mem_readdata;
              end else begin
                r_dc_done <= 1'b1;
                if (r_op == OP_RD) r_dc_readdata <= mem_readdata;
              end
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ic_busywait   = w_ic_req & ~r_ic_done;
  assign dc_busywait   = w_dc_req & ~r_dc_done;
  assign ic_readdata   = r_ic_readdata;
  assign dc_readdata   = r_dc_readdata;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter. Inputs change and outputs are
// sampled on the falling edge; cycle N is the period after the Nth rising edge
// counted from the cycle the request is first presented (cycle 0).
module tb_mem_block_arbiter;

  logic          clock = 1'b0;
  logic          reset;
  logic          ic_read;
  logic [27:0]   ic_address;
  logic [127:0]  ic_readdata;
  logic          ic_busywait;
  logic          dc_read;
  logic          dc_write;
  logic [27:0]   dc_address;
  logic [127:0]  dc_writedata;
  logic [127:0]  dc_readdata;
  logic          dc_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_address;
  logic [127:0]  mem_writedata;
  logic [127:0]  mem_readdata;
  logic          mem_busywait;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_block_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .ic_read       (ic_read),
    .ic_address    (ic_address),
    .ic_readdata   (ic_readdata),
    .ic_busywait   (ic_busywait),
    .dc_read       (dc_read),
    .dc_write      (dc_write),
    .dc_address    (dc_address),
    .dc_writedata  (dc_writedata),
    .dc_readdata   (dc_readdata),
    .dc_busywait   (dc_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Memory contents: each block is a pattern derived from its address
  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [31:0] w;
    w = {a, 4'h0} ^ 32'h5A5A_3C3C;
    return {4{w}};
  endfunction

  assign mem_readdata = blk(mem_address);

  task automatic reset_dut();
    reset = 1'b0;
    ic_read = 0; ic_address = '0;
    dc_read = 0; dc_write = 0; dc_address = '0; dc_writedata = '0;
    mem_busywait = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ic_read = 0; ic_address = '0;
    dc_read = 0; dc_write = 0; dc_address = '0; dc_writedata = '0;
    mem_busywait = 0;
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_read, mem_write, ic_busywait, dc_busywait} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_read, mem_write, ic_busywait, dc_busywait});
    end
    checks++;
    if (mem_address !== 28'h0 || mem_writedata !== 128'h0) begin
      errors++; $display("FAIL reset_port got=%h/%h exp=0/0", mem_address, mem_writedata);
    end
    checks++;
    if (ic_readdata !== 128'h0 || dc_readdata !== 128'h0) begin
      errors++; $display("FAIL reset_readdata got=%h/%h exp=0/0", ic_readdata, dc_readdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_ic_read();
    reset_dut();
    ic_address = 28'h0000010; ic_read = 1; #1;
    checks++;
    if (ic_busywait !== 1'b1) begin
      errors++; $display("FAIL ic_rd_busy cyc=0 got=%b exp=1", ic_busywait);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checks++;
      if (mem_read !== 1'(c < 3)) begin
        errors++; $display("FAIL ic_rd_strobe cyc=%0d got=%b exp=%b", c, mem_read, 1'(c < 3));
      end
      checks++;
      if (ic_busywait !== 1'(c < 3)) begin
        errors++; $display("FAIL ic_rd_busy cyc=%0d got=%b exp=%b", c, ic_busywait, 1'(c < 3));
      end
    end
    checks++;
    if (mem_address !== 28'h0000010) begin
      errors++; $display("FAIL ic_rd_addr got=%h exp=0000010", mem_address);
    end
    checks++;
    if (ic_readdata !== blk(28'h0000010)) begin
      errors++; $display("FAIL ic_rd_data got=%h exp=%h", ic_readdata, blk(28'h0000010));
    end
    ic_read = 0;
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b0 || ic_readdata !== blk(28'h0000010)) begin
      errors++; $display("FAIL ic_rd_hold got=%b/%h", mem_read, ic_readdata);
    end
  endtask

  task automatic test_dc_write();
    reset_dut();
    dc_address = 28'h0000020; dc_writedata = {16{8'hA5}}; dc_write = 1;
    mem_busywait = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      checks++;
      if (mem_write !== 1'(c <= 5) || mem_read !== 1'b0) begin
        errors++; $display("FAIL dc_wr_strobe cyc=%0d got=%b%b exp=%b0", c, mem_write, mem_read, 1'(c <= 5));
      end
      checks++;
      if (dc_busywait !== 1'(c <= 5)) begin
        errors++; $display("FAIL dc_wr_busy cyc=%0d got=%b exp=%b", c, dc_busywait, 1'(c <= 5));
      end
      if (c <= 5) begin
        checks++;
        if (mem_writedata !== {16{8'hA5}} || mem_address !== 28'h0000020) begin
          errors++; $display("FAIL dc_wr_port cyc=%0d got=%h/%h", c, mem_address, mem_writedata);
        end
      end
      mem_busywait = (c < 5) ? 1'b1 : 1'b0;
    end
    checks++;
    if (dc_readdata !== 128'h0) begin
      errors++; $display("FAIL dc_wr_readdata got=%h exp=0", dc_readdata);
    end
    dc_write = 0;
  endtask

  task automatic test_tie();
    int n;
    logic [27:0] exp_second;
    reset_dut();
    ic_address = 28'h0000100; dc_address = 28'h0000200;
    ic_read = 1; dc_read = 1;
    @(negedge clock);
    checks++;
    if (mem_address !== 28'h0000200 || mem_read !== 1'b1) begin
      errors++; $display("FAIL tie1_winner got=%h/%b exp=0000200/1", mem_address, mem_read);
    end
    n = 0;
    while (dc_busywait === 1'b1 && n < 20) begin
      @(negedge clock); n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL tie1_timeout got=%0d cycles exp<20", n);
    end
    checks++;
    if (dc_readdata !== blk(28'h0000200) || ic_busywait !== 1'b1) begin
      errors++; $display("FAIL tie1_result got=%h/%b exp=%h/1", dc_readdata, ic_busywait, blk(28'h0000200));
    end
    dc_address = 28'h0000300;
    repeat (2) @(negedge clock);
`ifdef ARB_ROUND_ROBIN_EN
    exp_second = 28'h0000100;
`else
    exp_second = 28'h0000300;
`endif
    checks++;
    if (mem_address !== exp_second || mem_read !== 1'b1) begin
      errors++; $display("FAIL tie2_winner got=%h/%b exp=%h/1", mem_address, mem_read, exp_second);
    end
    n = 0;
    while ((ic_read || dc_read) && n < 40) begin
      @(negedge clock); n++;
      if (ic_read && !ic_busywait) ic_read = 0;
      if (dc_read && !dc_busywait) dc_read = 0;
    end
    checks++;
    if (n >= 40) begin
      errors++; $display("FAIL tie_drain_timeout got=%0d cycles exp<40", n);
    end
    checks++;
    if (ic_readdata !== blk(28'h0000100) || dc_readdata !== blk(28'h0000300)) begin
      errors++; $display("FAIL tie_final_data got=%h/%h", ic_readdata, dc_readdata);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ic_address = 28'h0000050; ic_read = 1;
    repeat (3) @(negedge clock);
    ic_read = 0;
    @(negedge clock);
    checks++;
    if (ic_readdata !== blk(28'h0000050)) begin
      errors++; $display("FAIL rstmid_pre got=%h exp=%h", ic_readdata, blk(28'h0000050));
    end
    ic_address = 28'h0000040; ic_read = 1; mem_busywait = 1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b0 || ic_readdata !== 128'h0 || ic_busywait !== 1'b1) begin
      errors++; $display("FAIL rstmid_state got=%b/%h/%b exp=0/0/1", mem_read, ic_readdata, ic_busywait);
    end
    reset = 1'b1; mem_busywait = 0;
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 28'h0000040) begin
      errors++; $display("FAIL rstmid_reissue got=%b/%h exp=1/0000040", mem_read, mem_address);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (ic_busywait !== 1'b0 || ic_readdata !== blk(28'h0000040)) begin
      errors++; $display("FAIL rstmid_done got=%b/%h exp=0/%h", ic_busywait, ic_readdata, blk(28'h0000040));
    end
    ic_read = 0;
    @(negedge clock);
  endtask

  task automatic test_ic_drop();
    reset_dut();
    ic_address = 28'h0000070; ic_read = 1;
    repeat (3) @(negedge clock);
    ic_read = 0;
    @(negedge clock);
    ic_address = 28'h0000080; ic_read = 1; mem_busywait = 1;
    repeat (2) @(negedge clock);
    ic_read = 0; #1;
    checks++;
    if (dc_busywait !== 1'b0 || mem_read !== 1'b1) begin
      errors++; $display("FAIL drop_wait got=%b/%b exp=0/1", dc_busywait, mem_read);
    end
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 28'h0000080 || dc_busywait !== 1'b0) begin
      errors++; $display("FAIL drop_hold got=%b/%h/%b exp=1/0000080/0", mem_read, mem_address, dc_busywait);
    end
    mem_busywait = 0;
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b0 || ic_readdata !== blk(28'h0000070) || dc_busywait !== 1'b0) begin
      errors++; $display("FAIL drop_resp got=%b/%h/%b exp=0/%h/0", mem_read, ic_readdata, dc_busywait, blk(28'h0000070));
    end
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b0 || dc_busywait !== 1'b0 || ic_readdata !== blk(28'h0000070)) begin
      errors++; $display("FAIL drop_idle got=%b/%b/%h", mem_read, dc_busywait, ic_readdata);
    end
  endtask

  task automatic test_rw_both();
    reset_dut();
    dc_address = 28'h00000A0; dc_writedata = {4{32'h1234_5678}};
    dc_read = 1; dc_write = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checks++;
      if (mem_write !== 1'(c < 3) || mem_read !== 1'b0) begin
        errors++; $display("FAIL rw_strobe cyc=%0d got=%b%b exp=%b0", c, mem_write, mem_read, 1'(c < 3));
      end
    end
    checks++;
    if (dc_busywait !== 1'b0 || dc_readdata !== 128'h0) begin
      errors++; $display("FAIL rw_resp got=%b/%h exp=0/0", dc_busywait, dc_readdata);
    end
    dc_read = 0; dc_write = 0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_tie();
    test_reset_mid();
    test_ic_drop();
    test_rw_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
